// File: rtl/int_rx.sv
// Receive side of the UART calculator: parses "A<TERM>B<TERM>OP" ASCII frames
// from the RX FIFO into binary operands and an opcode for the ALU.
module int_rx #(
    parameter int unsigned NBIT = 8,
    parameter logic [7:0]  TERM = 8'h20
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            fifo_empty,
    input  logic [7:0]      data_fifo,
    output logic            RD_FIFO,
    output logic [NBIT-1:0] DATO_A,
    output logic [NBIT-1:0] DATO_B,
    output logic [7:0]      OPCODE,
    output logic            LISTO,
    output logic            ERROR,
    output logic [2:0]      STATE
);

    localparam int unsigned PW = NBIT + 4;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NBIT-1:0] acc;
    logic [NBIT-1:0] reg_a;
    logic [NBIT-1:0] reg_b;
    logic [7:0]      reg_op;

    logic            is_digit;
    logic            is_term;
    logic [3:0]      digit;
    logic [PW-1:0]   acc_mac;
    logic [NBIT-1:0] acc_dec;

    logic            acc_load_c;
    logic            acc_clr_c;
    logic            lat_a_c;
    logic            lat_b_c;
    logic            lat_op_c;
    logic            clr_all_c;
    logic            publish_c;

    // Byte classification and decimal shift-in (wraps mod 2^NBIT)
    always_comb begin
        is_digit = (data_fifo >= 8'h30) && (data_fifo <= 8'h39);
        is_term  = (data_fifo == TERM);
        digit    = 4'(data_fifo - 8'h30);
        acc_mac  = ({4'd0, acc} * PW'(10)) + PW'(digit);
        acc_dec  = NBIT'(acc_mac);
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_A, S_B: begin
                if (!fifo_empty) begin
                    if (is_term) begin
                        state_nxt = (state == S_A) ? S_B : S_OP;
                    end else if (!is_digit) begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_OP: begin
                if (!fifo_empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_A;
            S_ERR:   state_nxt = S_A;
            default: state_nxt = S_A;
        endcase
    end

    // Pop strobe and datapath controls
    always_comb begin
        RD_FIFO    = 1'b0;
        acc_load_c = 1'b0;
        acc_clr_c  = 1'b0;
        lat_a_c    = 1'b0;
        lat_b_c    = 1'b0;
        lat_op_c   = 1'b0;
        clr_all_c  = 1'b0;
        publish_c  = 1'b0;
        case (state)
            S_A, S_B: begin
                if (!fifo_empty) begin
                    RD_FIFO = 1'b1;
                    if (is_digit) begin
                        acc_load_c = 1'b1;
                    end else if (is_term) begin
                        acc_clr_c = 1'b1;
                        lat_a_c   = (state == S_A);
                        lat_b_c   = (state == S_B);
                    end
                end
            end
            S_OP: begin
                if (!fifo_empty) begin
                    RD_FIFO  = 1'b1;
                    lat_op_c = 1'b1;
                end
            end
            S_DONE:  publish_c = 1'b1;
            S_ERR:   clr_all_c = 1'b1;
            default: ;
        endcase
    end

    // Frame assembly registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc    <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else if (clr_all_c) begin
            acc    <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (acc_load_c) begin
                acc <= acc_dec;
            end else if (acc_clr_c) begin
                acc <= '0;
            end
            if (lat_a_c) begin
                reg_a <= acc;
            end
            if (lat_b_c) begin
                reg_b <= acc;
            end
            if (lat_op_c) begin
                reg_op <= data_fifo;
            end
        end
    end

    // Published frame; values move only on the edge that raises LISTO
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DATO_A <= '0;
            DATO_B <= '0;
            OPCODE <= '0;
            LISTO  <= 1'b0;
            ERROR  <= 1'b0;
        end else begin
            LISTO <= publish_c;
            ERROR <= (state_nxt == S_ERR);
            if (publish_c) begin
                DATO_A <= reg_a;
                DATO_B <= reg_b;
                OPCODE <= reg_op;
            end
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_int_rx.sv
// Randomised and directed bench for int_rx against a byte-stream frame parser model.
module tb_int_rx;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       fifo_empty;
    logic [7:0] data_fifo;
    logic       RD_FIFO;
    logic [7:0] DATO_A;
    logic [7:0] DATO_B;
    logic [7:0] OPCODE;
    logic       LISTO;
    logic       ERROR;
    logic [2:0] STATE;

    int_rx #(.NBIT(8), .TERM(8'h20)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .fifo_empty (fifo_empty),
        .data_fifo  (data_fifo),
        .RD_FIFO    (RD_FIFO),
        .DATO_A     (DATO_A),
        .DATO_B     (DATO_B),
        .OPCODE     (OPCODE),
        .LISTO      (LISTO),
        .ERROR      (ERROR),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // FIFO contents and pacing
    byte unsigned q[$];
    int  gap_cfg  = 0;
    int  hold     = 0;
    bit  rnd_gaps = 0;

    // Behavioural parser model
    int  iter      = 0;
    int  field     = 0;
    int  acc       = 0;
    int  fa        = 0;
    int  fb        = 0;
    int  busy_now  = 0;
    int  busy_next = 0;
    bit  listo_at[int];
    bit  err_at[int];
    int  pa[int];
    int  pb[int];
    int  po[int];
    int  exp_a     = 0;
    int  exp_b     = 0;
    int  exp_op    = 0;

    int  pops      = 0;
    int  listo_cnt = 0;
    int  err_cnt   = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d iter=%0d", name, act, expv, iter);
        end
    endtask

    task automatic model_reset();
        field = 0; acc = 0; busy_now = 0; busy_next = 0;
        exp_a = 0; exp_b = 0; exp_op = 0; hold = 0;
        listo_at.delete(); err_at.delete();
        pa.delete(); pb.delete(); po.delete();
        q.delete();
    endtask

    task automatic model_byte(input byte unsigned b);
        if (field < 2) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                acc = (acc * 10 + (int'(b) - 48)) % 256;
            end else if (b == 8'h20) begin
                if (field == 0) fa = acc; else fb = acc;
                acc = 0;
                field++;
            end else begin
                err_at[iter + 1] = 1'b1;
                field = 0; acc = 0; fa = 0; fb = 0;
                busy_next = 4;
            end
        end else begin
            listo_at[iter + 2] = 1'b1;
            pa[iter + 2] = fa;
            pb[iter + 2] = fb;
            po[iter + 2] = int'(b);
            field = 0; acc = 0;
            busy_next = 3;
        end
    endtask

    // One clock: compare registered outputs, drive FIFO, check and apply pop
    task automatic step();
        bit exp_listo;
        bit exp_err;
        bit empty;
        int exp_state;
        @(negedge CLK);
        exp_listo = listo_at.exists(iter);
        exp_err   = err_at.exists(iter);
        if (exp_listo) begin
            exp_a = pa[iter]; exp_b = pb[iter]; exp_op = po[iter];
        end
        exp_state = (busy_now != 0) ? busy_now : field;
        chk("listo",  int'(LISTO),  int'(exp_listo));
        chk("error",  int'(ERROR),  int'(exp_err));
        chk("dato_a", int'(DATO_A), exp_a);
        chk("dato_b", int'(DATO_B), exp_b);
        chk("opcode", int'(OPCODE), exp_op);
        chk("state",  int'(STATE),  exp_state);
        if (LISTO) listo_cnt++;
        if (ERROR) err_cnt++;

        if (hold > 0) begin
            empty = 1'b1; hold--;
        end else if (q.size() == 0) begin
            empty = 1'b1;
        end else if (rnd_gaps && $urandom_range(0, 3) == 0) begin
            empty = 1'b1;
        end else begin
            empty = 1'b0;
        end
        fifo_empty = empty;
        data_fifo  = empty ? 8'($urandom) : q[0];
        #1;
        chk("rd_fifo", int'(RD_FIFO), int'(!empty && busy_now == 0));
        if (RD_FIFO && !empty) begin
            model_byte(q.pop_front());
            pops++;
            hold = gap_cfg;
        end
        busy_now  = busy_next;
        busy_next = 0;
        iter++;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20000) begin
            step();
            guard++;
        end
        chk("drain_timeout", int'(q.size() > 0), 0);
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic run_frame(input string s);
        pops = 0; listo_cnt = 0; err_cnt = 0;
        push_str(s);
        drain();
    endtask

    task automatic pin(input int a, input int b, input int op, input int nl, input int ne);
        chk("pin_a",     int'(DATO_A), a);
        chk("pin_b",     int'(DATO_B), b);
        chk("pin_op",    int'(OPCODE), op);
        chk("pin_listo", listo_cnt,    nl);
        chk("pin_error", err_cnt,      ne);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N    = 1'b0;
        fifo_empty = 1'b1;
        #1;
        chk("rst_a",     int'(DATO_A),  0);
        chk("rst_b",     int'(DATO_B),  0);
        chk("rst_op",    int'(OPCODE),  0);
        chk("rst_listo", int'(LISTO),   0);
        chk("rst_error", int'(ERROR),   0);
        chk("rst_state", int'(STATE),   0);
        chk("rst_rd",    int'(RD_FIFO), 0);
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        byte unsigned opb;
        int nd;
        RESET_N    = 1'b0;
        fifo_empty = 1'b1;
        data_fifo  = 8'h00;
        repeat (2) @(negedge CLK);
        do_reset();

        run_frame("12 7 +");
        pin(12, 7, 8'h2B, 1, 0);
        chk("pops_12_7", pops, 6);

        run_frame("300 5 -");
        pin(44, 5, 8'h2D, 1, 0);

        gap_cfg = 5;
        run_frame("12 7 +");
        pin(12, 7, 8'h2B, 1, 0);
        gap_cfg = 0;

        run_frame("1x");
        pin(12, 7, 8'h2B, 0, 1);

        run_frame("4 2 *");
        pin(4, 2, 8'h2A, 1, 0);

        run_frame("  &");
        pin(0, 0, 8'h26, 1, 0);

        push_str("9");
        drain();
        do_reset();
        run_frame("3 3 +");
        pin(3, 3, 8'h2B, 1, 0);

        run_frame("5 6 -7 8 /");
        pin(7, 8, 8'h2F, 2, 0);

        // Random frames with occasional junk bytes and random FIFO stalls
        rnd_gaps = 1;
        for (int f = 0; f < 200; f++) begin
            for (int fld = 0; fld < 2; fld++) begin
                nd = $urandom_range(0, 3);
                for (int d = 0; d < nd; d++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                if ($urandom_range(0, 11) == 0) q.push_back(8'(8'h41 + $urandom_range(0, 25)));
                q.push_back(8'h20);
            end
            opb = 8'($urandom);
            q.push_back(opb);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
